// File: rtl/izh_pkg.sv
// Shared definitions for the synaptic accumulation datapath: sweep state
// encoding, default geometry and the clamp bounds used by the optional
// saturating output stage.
package izh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NEURON_ADR_DFLT = 5;
  localparam int WEIGHTS_DFLT    = 31;
  // Headroom for 64 full-scale weights: weight width plus address width.
  localparam int ACC_W_DFLT      = WEIGHTS_DFLT + 1 + NEURON_ADR_DFLT + 1;

  // Number of presynaptic neurons addressed by a (neuron_adr+1)-bit address.
  function automatic int num_pre(input int neuron_adr);
    return 2 ** (neuron_adr + 1);
  endfunction

  // Largest value representable by a signed (weights+1)-bit word.
  function automatic longint sat_max(input int weights);
    return (64'sd1 <<< weights) - 64'sd1;
  endfunction

  // Smallest value representable by a signed (weights+1)-bit word.
  function automatic longint sat_min(input int weights);
    return -(64'sd1 <<< weights);
  endfunction

endpackage

// File: rtl/syn_accum_sat.sv
// Combinational signed clamp of the full-width sum to the weight-word range,
// result sign-extended back to the accumulator width. Used only when
// SYN_ACCUM_SAT_EN is defined.
module syn_sat
  import izh_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DFLT,
  parameter int WEIGHTS = WEIGHTS_DFLT
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(WEIGHTS));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(WEIGHTS));

  // Clamp to [MIN_V, MAX_V]; in-range values pass unchanged.
  always_comb begin
    sat_o = acc_i;
    if (acc_i > MAX_V) begin
      sat_o = MAX_V;
    end else if (acc_i < MIN_V) begin
      sat_o = MIN_V;
    end
  end

endmodule

// File: rtl/syn_accum.sv
// Synaptic current accumulator for one postsynaptic neuron. Sweeps every
// address of the paired weight RAM through its combinational read port and
// sums the weights of the presynaptic neurons that spiked this time step.
// Optional output clamp to the weight-word range: define SYN_ACCUM_SAT_EN.
//
// state | meaning
// IDLE  | waiting for start; ready high
// SCAN  | one RAM address per cycle, conditionally accumulated
// DONE  | result just published on i_syn; i_valid high for this cycle
module syn_accum
  import izh_pkg::*;
#(
  parameter int NEURON_ADR = NEURON_ADR_DFLT,
  parameter int WEIGHTS    = WEIGHTS_DFLT,
  parameter int ACC_W      = ACC_W_DFLT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [num_pre(NEURON_ADR)-1:0]     spikes,
  output logic                               ready,
  output logic [NEURON_ADR:0]                dpra,
  input  logic [WEIGHTS:0]                   dpo,
  output logic signed [ACC_W-1:0]            i_syn,
  output logic                               i_valid
);

  localparam int NUM_PRE = num_pre(NEURON_ADR);
  localparam int AW      = NEURON_ADR + 1;
  localparam logic [AW-1:0] LAST_ADR = AW'(NUM_PRE - 1);

  state_t                   state_q, state_d;
  logic [NUM_PRE-1:0]       spk_q, spk_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            dpra_q, dpra_d;
  logic signed [ACC_W-1:0]  i_syn_q, i_syn_d;
  logic                     i_valid_q, i_valid_d;

  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  result;

  // Sign-extend the current weight and add it only if that neuron spiked.
  always_comb begin
    w_ext   = {{(ACC_W-WEIGHTS-1){dpo[WEIGHTS]}}, dpo};
    acc_sum = acc_q;
    if (spk_q[dpra_q]) begin
      acc_sum = acc_q + w_ext;
    end
  end

`ifdef SYN_ACCUM_SAT_EN
  syn_sat #(
    .ACC_W   (ACC_W),
    .WEIGHTS (WEIGHTS)
  ) u_sat (
    .acc_i (acc_sum),
    .sat_o (result)
  );
`else
  assign result = acc_sum;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      spk_q     <= '0;
      acc_q     <= '0;
      dpra_q    <= '0;
      i_syn_q   <= '0;
      i_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      spk_q     <= spk_d;
      acc_q     <= acc_d;
      dpra_q    <= dpra_d;
      i_syn_q   <= i_syn_d;
      i_valid_q <= i_valid_d;
    end
  end

  // Next-state and datapath update; i_syn only changes on SCAN -> DONE.
  always_comb begin
    state_d   = state_q;
    spk_d     = spk_q;
    acc_d     = acc_q;
    dpra_d    = dpra_q;
    i_syn_d   = i_syn_q;
    i_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          spk_d   = spikes;
          acc_d   = '0;
          dpra_d  = '0;
        end
      end
      SCAN: begin
        acc_d  = acc_sum;
        dpra_d = dpra_q + AW'(1);
        if (dpra_q == LAST_ADR) begin
          state_d   = DONE;
          i_syn_d   = result;
          i_valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready   = (state_q == IDLE);
  assign dpra    = dpra_q;
  assign i_syn   = i_syn_q;
  assign i_valid = i_valid_q;

endmodule

// File: tb/tb_syn_accum.sv
// Self-checking bench for syn_accum with a behavioural weight RAM and a
// plain-arithmetic reference sum.
module tb_syn_accum;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [63:0]        spikes;
  logic               ready;
  logic [5:0]         dpra;
  logic [31:0]        dpo;
  logic signed [37:0] i_syn;
  logic               i_valid;

  logic [31:0] ram [64];
  int total = 0;
  int bad   = 0;

  int          lat, rdy_low, vcnt;
  logic [5:0]  dpra_log [64];
  logic [5:0]  dpra_end;

  syn_accum dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .spikes  (spikes),
    .ready   (ready),
    .dpra    (dpra),
    .dpo     (dpo),
    .i_syn   (i_syn),
    .i_valid (i_valid)
  );

  assign dpo = ram[dpra];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum of signed weights of spiking neurons, optionally clamped.
  function automatic longint ref_sum(input logic [63:0] spk);
    longint s = 0;
    for (int k = 0; k < 64; k++)
      if (spk[k]) s += longint'($signed(ram[k]));
`ifdef SYN_ACCUM_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s;
  endfunction

  // One sweep: start accepted at edge 0; measures latency, ready-low cycles,
  // number of i_valid pulses and the address sequence. Bounded to 80 edges.
  task automatic do_sweep(input logic [63:0] spk, input bit hold);
    @(posedge clk); #1;
    spikes = spk;
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    spikes  = {$urandom, $urandom};
    lat     = -1;
    rdy_low = 0;
    vcnt    = 0;
    for (int e = 1; e <= 80; e++) begin
      if (e <= 64) dpra_log[e-1] = dpra;
      if (!ready) rdy_low++;
      if (hold && e == 60) start = 1'b0;
      @(posedge clk); #1;
      if (e == 64) dpra_end = dpra;
      if (i_valid) begin
        vcnt++;
        if (lat < 0) lat = e;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; spikes = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || dpra !== 6'd0 || i_syn !== 38'sd0 || i_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: ready=%b dpra=%0d i_syn=%0d i_valid=%b expected 1/0/0/0",
               ready, dpra, i_syn, i_valid);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_all_ones;
    for (int k = 0; k < 64; k++) ram[k] = 32'd1;
    do_sweep({64{1'b1}}, 1'b0);
    total++;
    if (lat !== 64) begin bad++; $display("FAIL ones_latency: got %0d expected 64", lat); end
    total++;
    if (i_syn !== 38'sd64) begin bad++; $display("FAIL ones_sum: got %0d expected 64", i_syn); end
    total++;
    if (rdy_low !== 65) begin bad++; $display("FAIL ones_ready_low: got %0d expected 65", rdy_low); end
    total++;
    if (vcnt !== 1) begin bad++; $display("FAIL ones_valid_count: got %0d expected 1", vcnt); end
  endtask

  task automatic test_neg_last;
    int errs = 0;
    int first_bad = -1;
    for (int k = 0; k < 64; k++) ram[k] = 32'd100;
    ram[63] = 32'hFFFFFFFB;
    do_sweep(64'h1 << 63, 1'b0);
    total++;
    if (longint'(i_syn) !== -64'sd5) begin bad++; $display("FAIL neg_sum: got %0d expected -5", i_syn); end
    for (int k = 0; k < 64; k++)
      if (dpra_log[k] !== 6'(k)) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL dpra_seq: at cycle %0d got %0d expected %0d", first_bad,
               dpra_log[first_bad], first_bad);
    end
    total++;
    if (dpra_end !== 6'd0) begin bad++; $display("FAIL dpra_wrap: got %0d expected 0", dpra_end); end
  endtask

  task automatic test_zero_spikes_held_start;
    for (int k = 0; k < 64; k++) ram[k] = $urandom;
    do_sweep(64'h0, 1'b1);
    total++;
    if (i_syn !== 38'sd0) begin bad++; $display("FAIL zero_sum: got %0d expected 0", i_syn); end
    total++;
    if (lat !== 64) begin bad++; $display("FAIL zero_latency: got %0d expected 64", lat); end
    total++;
    if (vcnt !== 1) begin bad++; $display("FAIL held_start_valids: got %0d expected 1", vcnt); end
  endtask

  task automatic test_extremes;
    longint exp_pos, exp_neg;
`ifdef SYN_ACCUM_SAT_EN
    exp_pos = 64'sd2147483647;
    exp_neg = -64'sd2147483648;
`else
    exp_pos = 64'sd137438953408;
    exp_neg = -64'sd137438953472;
`endif
    for (int k = 0; k < 64; k++) ram[k] = 32'h7FFFFFFF;
    do_sweep({64{1'b1}}, 1'b0);
    total++;
    if (longint'(i_syn) !== exp_pos) begin
      bad++; $display("FAIL max_sum: got %0d expected %0d", i_syn, exp_pos);
    end
    for (int k = 0; k < 64; k++) ram[k] = 32'h80000000;
    do_sweep({64{1'b1}}, 1'b0);
    total++;
    if (longint'(i_syn) !== exp_neg) begin
      bad++; $display("FAIL min_sum: got %0d expected %0d", i_syn, exp_neg);
    end
  endtask

  task automatic test_reset_mid_scan;
    int v = 0;
    for (int k = 0; k < 64; k++) ram[k] = 32'd1;
    do_sweep({64{1'b1}}, 1'b0);
    total++;
    if (i_syn !== 38'sd64) begin bad++; $display("FAIL pre_reset_sum: got %0d expected 64", i_syn); end
    @(posedge clk); #1;
    spikes = {64{1'b1}};
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (i_syn !== 38'sd0 || i_valid !== 1'b0 || ready !== 1'b1 || dpra !== 6'd0) begin
      bad++;
      $display("FAIL mid_reset: i_syn=%0d i_valid=%b ready=%b dpra=%0d expected 0/0/1/0",
               i_syn, i_valid, ready, dpra);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < 70; e++) begin
      @(posedge clk); #1;
      if (i_valid) v++;
    end
    total++;
    if (v !== 0) begin bad++; $display("FAIL post_reset_valid: got %0d pulses expected 0", v); end
    ram[0] = 32'd7;
    do_sweep(64'h1, 1'b0);
    total++;
    if (i_syn !== 38'sd7) begin bad++; $display("FAIL post_reset_sum: got %0d expected 7", i_syn); end
  endtask

  task automatic test_alternate;
    for (int k = 0; k < 64; k++) ram[k] = 32'(k);
    do_sweep(64'h5555_5555_5555_5555, 1'b0);
    total++;
    if (i_syn !== 38'sd992) begin bad++; $display("FAIL alt_sum: got %0d expected 992", i_syn); end
  endtask

  task automatic test_random;
    logic [63:0] spk;
    longint exp;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 64; k++) ram[k] = $urandom;
      if (it == 0) for (int k = 0; k < 64; k++) ram[k] = 32'h80000000 | $urandom;
      spk = {$urandom, $urandom};
      exp = ref_sum(spk);
      do_sweep(spk, 1'b0);
      total++;
      if (longint'(i_syn) !== exp || lat !== 64) begin
        bad++;
        $display("FAIL random_%0d: got %0d lat %0d expected %0d lat 64", it, i_syn, lat, exp);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) ram[k] = '0;
    test_reset;
    test_all_ones;
    test_neg_last;
    test_zero_spikes_held_start;
    test_extremes;
    test_reset_mid_scan;
    test_alternate;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
